// File: rtl/csa_pkg.sv
// csa_pkg: shared state type and sizing helper for the carry-save accumulator
package csa_pkg;
    typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} accum_state_t;

    function automatic int cdiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
endpackage

// File: rtl/csa_row.sv
// csa_row: combinational W-bit 3:2 compressor, carry pre-shifted with its MSB dropped
module csa_row #(
    parameter int W = 9
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);
    assign s = x ^ y ^ z;
    assign c = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};
endmodule

// File: rtl/csa_accum.sv
// csa_accum: carry-save multi-operand accumulator with chunked final resolve
// CSA_ACCUM_SIGNED_EN: operands are two's complement and sign-extended
module csa_accum
    import csa_pkg::*;
#(
    parameter int N       = 5,
    parameter int MAX_OPS = 16,
    parameter int CHUNK   = 4,
    localparam int LW     = $clog2(MAX_OPS),
    localparam int ACC_W  = N + LW,
    localparam int CW     = LW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CW-1:0]    out_count
);
    localparam int R  = cdiv(ACC_W, CHUNK);
    localparam int PW = R * CHUNK;
    localparam int JW = $clog2(R + 1);

    accum_state_t   state;
    logic [ACC_W-1:0] sum_r, carry_r, op, row_s, row_c;
    logic [CW-1:0]  count;
    logic [JW-1:0]  j;
    logic           cy;
    logic [PW-1:0]  res;
    logic [CHUNK:0] add;

`ifdef CSA_ACCUM_SIGNED_EN
    assign op = {{LW{in_data[N-1]}}, in_data};
`else
    assign op = {{LW{1'b0}}, in_data};
`endif

    assign in_ready = state == ACCUM;
    assign add = {1'b0, sum_r[CHUNK-1:0]} + {1'b0, carry_r[CHUNK-1:0]} + (CHUNK+1)'(cy);

    csa_row #(.W(ACC_W)) u_row (.x(sum_r), .y(carry_r), .z(op), .s(row_s), .c(row_c));

    // RESOLVE shifts sum_r/carry_r down one chunk per cycle and stacks chunk sums
    // into res; the extra cycle at j==R loads the result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            sum_r     <= '0;
            carry_r   <= '0;
            count     <= '0;
            j         <= '0;
            cy        <= 1'b0;
            res       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ACCUM: if (in_valid) begin
                    sum_r   <= row_s;
                    carry_r <= row_c;
                    count   <= count + 1'b1;
                    if (in_last || count == CW'(MAX_OPS - 1)) begin
                        state <= RESOLVE;
                        j     <= '0;
                        cy    <= 1'b0;
                    end
                end
                RESOLVE: if (j == JW'(R)) begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    out_sum   <= res[ACC_W-1:0];
                    out_count <= count;
                end else begin
                    sum_r   <= sum_r >> CHUNK;
                    carry_r <= carry_r >> CHUNK;
                    cy      <= add[CHUNK];
                    res     <= PW'({add[CHUNK-1:0], res} >> CHUNK);
                    j       <= j + 1'b1;
                end
                DONE: if (out_ready) begin
                    state     <= ACCUM;
                    out_valid <= 1'b0;
                    sum_r     <= '0;
                    carry_r   <= '0;
                    count     <= '0;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accum.sv
// tb_csa_accum: scoreboard bench for csa_accum, directed cases plus random stalls
module tb_csa_accum;
    localparam int N = 5, MAX_OPS = 16, CHUNK = 4, ACC_W = 9, CW = 5;

    typedef struct {
        logic [ACC_W-1:0] s;
        logic [CW-1:0]    c;
    } exp_t;

    logic clk = 0, rst = 1;
    logic in_valid = 0, in_last = 0, out_ready = 0;
    logic [N-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [ACC_W-1:0] out_sum;
    logic [CW-1:0] out_count;

    int checks = 0, errors = 0;
    exp_t q[$];
    int acc = 0, cnt = 0;
    logic or_fix = 0, rnd = 0;

    csa_accum #(.N(N), .MAX_OPS(MAX_OPS), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [N-1:0] d, input logic l);
        int t = 0;
        logic rdy;
        exp_t e;
        in_valid = 1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!rdy && t < 200);
        in_valid = 0;
        in_last  = 0;
        if (!rdy) check("send_timeout", 0, 1);
        else begin
`ifdef CSA_ACCUM_SIGNED_EN
            acc += int'($signed(d));
`else
            acc += int'(d);
`endif
            cnt++;
            if (l || cnt == MAX_OPS) begin
                e.s = ACC_W'(acc);
                e.c = CW'(cnt);
                q.push_back(e);
                acc = 0;
                cnt = 0;
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : or_fix;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) check("unexpected_result", 1, 0);
            else begin
                e = q.pop_front();
                check("out_sum", out_sum, e.s);
                check("out_count", out_count, e.c);
                check("in_ready_in_done", in_ready, 0);
            end
            @(negedge clk);
            check("out_valid_drop", out_valid, 0);
            check("in_ready_back", in_ready, 1);
        end
    end

    initial begin
        int n;
        exp_t e;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_count", out_count, 0);
        @(posedge clk);
        #1;

        send(10, 1);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 4);
        @(posedge clk);
        #1 or_fix = 1;
        drain();

        send(4, 0);
        send(6, 0);
        send(12, 1);
        check("in_ready_after_last", in_ready, 0);
        drain();

        for (int i = 0; i < MAX_OPS; i++) send(31, 0);
        check("in_ready_after_max", in_ready, 0);
        check("implicit_last_queued", q.size(), 1);
        drain();

        or_fix = 0;
        repeat (2) @(posedge clk);
        #1;
        send(15, 0);
        send(15, 0);
        send(15, 1);
        n = 0;
        while (n < 20 && !out_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = q[0];
        check("bp_expect_45", e.s, 45);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_sum", out_sum, 45);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 or_fix = 1;
        drain();

        send(11, 0);
        send(2, 1);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        q.delete();
        acc = 0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            check("no_valid_after_rst", out_valid, 0);
        end
        check("rst_mid_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(20, 0);
        send(20, 1);
        e = q[0];
`ifdef CSA_ACCUM_SIGNED_EN
        check("post_rst_expect", e.s, 9'h1E8);
`else
        check("post_rst_expect", e.s, 40);
`endif
        drain();

        rnd = 1;
        for (int p = 0; p < 1000; p++) begin
            int len;
            len = $urandom_range(1, 18);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send(N'($urandom_range(0, 31)), i == len - 1);
            end
        end
        drain();
        rnd = 0;
        check("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csa_accum.md
Name: csa_accum

Overview:
- Sequential multi-operand accumulator that sits directly downstream of the team's carry-save adder cell.
- It keeps a running total in carry-save form: a sum vector and a carry vector, updated with one 3:2 compression per accepted operand.
- At packet end it resolves the redundant pair with a chunked carry-propagate adder and emits one binary result.
- Operands arrive on a valid/ready stream; results leave on a valid/ready stream.

Parameters:
- N, 5: operand width in bits.
- MAX_OPS, 16: maximum operands per packet; must be a power of 2, ≥2.
- CHUNK, 4: bits resolved per cycle in the final carry-propagate phase; 1 ≤ CHUNK ≤ ACC_W.
- ACC_W (localparam) = N + $clog2(MAX_OPS): accumulator and result width.
- R (localparam) = ceil(ACC_W/CHUNK): number of resolve cycles. Defaults give ACC_W=9, R=3.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand.
- in_data  in  N  operand.
- in_last  in  1  final operand of the packet; qualified by in_valid.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  resolved packet sum.
- out_count  out  $clog2(MAX_OPS)+1  number of operands in the packet.

Behaviour:
- States: ACCUM, RESOLVE, DONE.
- Reset: state=ACCUM; sum_r, carry_r, count, out_sum, out_count all 0; out_valid=0; in_ready=1 in the first cycle after reset.
- Reset mid-packet (any state) discards all partial data. No result is emitted.
- in_ready=1 only in ACCUM. A transfer happens on an edge with in_valid && in_ready.
- On each transfer, with op = in_data zero-extended to ACC_W:
  - sum_r <= sum_r ^ carry_r ^ op
  - carry_r <= (majority(sum_r, carry_r, op) << 1), truncated to ACC_W
  - count++
  - No carry propagation happens in ACCUM, so one operand is accepted per cycle.
- Implicit last: a transfer with in_last=1, or the MAX_OPS-th transfer, ends the packet and moves to RESOLVE on the same edge.
- Operands beyond MAX_OPS are impossible; they are back-pressured because in_ready is already low.
- A packet always has at least 1 operand.
- RESOLVE: R cycles. Chunk j (bits j*CHUNK up to min((j+1)*CHUNK, ACC_W)-1) adds sum_r + carry_r plus the carry registered from chunk j-1. Carry out of bit ACC_W-1 is dropped; it is provably 0 when MAX_OPS is a power of 2.
- After the R-th resolve edge: state=DONE, out_valid=1, out_sum and out_count loaded.
- Latency: if the last operand is accepted at edge k, out_valid is first high after edge k+R+1. Default: 4 cycles.
- DONE: out_sum and out_count are stable while out_valid=1 && !out_ready.
- Result handshake: on an edge with out_ready=1, out_valid drops, sum_r/carry_r/count clear, and state returns to ACCUM. in_ready=1 the next cycle, so there is a one-bubble turnaround.
- in_valid or in_last outside ACCUM is ignored.
- out_ready outside DONE is ignored.

Optional Feature:
- Macro: CSA_ACCUM_SIGNED_EN.
- Defined: in_data is two's complement and is sign-extended to ACC_W before compression. out_sum is a two's-complement ACC_W-bit sum, exact for up to MAX_OPS operands.
- Undefined: operands are unsigned and zero-extended.
- Port list, timing and handshakes are identical in both builds.

Decomposition:
- Shared package csa_pkg:
  - state enum type accum_state_t {ACCUM, RESOLVE, DONE}.
  - function for ceil-div, used to compute R.
- Sub-module csa_row: a purely combinational ACC_W-bit 3:2 compressor (inputs x, y, z; outputs s, c). The carry is pre-shifted with the MSB dropped. It is instantiated once in the ACCUM datapath.
- The resolve chunk adder is inline.

Test Plan:
1. Single-operand packet: in_data=10, in_last=1 -> after 4 cycles out_valid=1, out_sum=10, out_count=1.
2. Back-to-back operands 4, 6, 12, last on 12, out_ready held 1 -> out_sum=22, out_count=3; in_ready low from the edge after the last transfer until one cycle after the result handshake.
3. Implicit last: 16 consecutive operands of 31 with in_last=0 -> out_sum=496, out_count=16; in_ready drops after the 16th transfer.
4. Backpressure: operands 15, 15, 15 with out_ready=0 for 5 cycles -> out_valid stays high, out_sum=45 stable, in_ready=0; release out_ready -> next packet accepted the following cycle.
5. Reset mid-RESOLVE after operands 11, 2 -> no out_valid; the post-reset packet of 20, 20 gives out_sum=40 unsigned. With CSA_ACCUM_SIGNED_EN, 20 is -12, so out_sum=-24, i.e. 9'h1E8.
6. Random stalls: in_valid randomly toggled over 1000 packets against a reference model -> out_sum and out_count always match, with no lost or duplicated operands.
